// File: rtl/vga_capture.sv
// vga_capture: samples the VGA generator outputs, rebuilds pixel coordinates,
// measures raster timing, locks to the nominal raster and signs each frame with CRC-16-CCITT.
module vga_capture #(
  parameter int H_TOTAL      = 1525,
  parameter int V_TOTAL      = 525,
  parameter int H_BACK_PORCH = 91,
  parameter int H_DISPLAY    = 1220,
  parameter int V_BACK_PORCH = 33,
  parameter int V_DISPLAY    = 480
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic        px_valid,
  output logic [10:0] px_x,
  output logic [8:0]  px_y,
  output logic [5:0]  px_rgb,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] line_period,
  output logic [9:0]  frame_lines,
  output logic        frame_done,
  output logic [15:0] frame_crc
);
  typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs1_q, hs2_q, vs1_q, vs2_q;
  logic [5:0]  rgb1_q;
  logic [10:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, line_period_q, line_period_d, px_x_q, px_x_d;
  logic [9:0]  lcnt_q, lcnt_d, frame_lines_q, frame_lines_d;
  logic [8:0]  px_y_q, px_y_d;
  logic [5:0]  px_rgb_q, px_rgb_d;
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
  logic        px_valid_q, px_valid_d, locked_q, locked_d, sync_err_q, sync_err_d;
  logic        frame_done_q, frame_done_d;
  logic        h_fall, h_rise, v_rise, sat, viol, act;
  logic [10:0] bp;

  function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  assign h_fall = hs2_q & ~hs1_q;
  assign h_rise = hs1_q & ~hs2_q;
  assign v_rise = vs1_q & ~vs2_q;
  // the hsync-rise cycle itself is back-porch cycle 0
  assign bp     = h_rise ? 11'd0 : hcnt_q;
  assign sat    = !h_fall && pcnt_q == 11'd2046;
  assign viol   = (h_fall && pcnt_q != 11'(H_TOTAL)) || (v_rise && lcnt_q != 10'(V_TOTAL)) || sat;
  assign act    = lcnt_q >= 10'(V_BACK_PORCH) && lcnt_q < 10'(V_BACK_PORCH + V_DISPLAY) &&
                  bp >= 11'(H_BACK_PORCH) && bp < 11'(H_BACK_PORCH + H_DISPLAY);

  always_comb begin
    pcnt_d        = h_fall ? 11'd1 : (&pcnt_q ? pcnt_q : pcnt_q + 11'd1);
    line_period_d = h_fall ? pcnt_q : line_period_q;
    lcnt_d        = v_rise ? {9'd0, h_rise} : (h_rise && !(&lcnt_q)) ? lcnt_q + 10'd1 : lcnt_q;
    frame_lines_d = v_rise ? lcnt_q : frame_lines_q;
    hcnt_d        = &bp ? bp : bp + 11'd1;
    state_d       = (state_q != UNLOCKED && viol) ? UNLOCKED :
                    (v_rise && state_q == UNLOCKED) ? MEASURE :
                    (v_rise && state_q == MEASURE) ? LOCKED : state_q;
    sync_err_d    = viol && state_q != UNLOCKED;
    locked_d      = state_d == LOCKED;
    px_valid_d    = act && state_q == LOCKED;
    px_x_d        = px_valid_d ? bp - 11'(H_BACK_PORCH) : px_x_q;
    px_y_d        = px_valid_d ? 9'(lcnt_q - 10'(V_BACK_PORCH)) : px_y_q;
    px_rgb_d      = px_valid_d ? rgb1_q : px_rgb_q;
    crc_d         = v_rise ? 16'hFFFF : act ? crc6(crc_q, rgb1_q) : crc_q;
    frame_done_d  = px_valid_q && px_x_q == 11'(H_DISPLAY - 1) && px_y_q == 9'(V_DISPLAY - 1);
    frame_crc_d   = frame_done_d ? crc_q : frame_crc_q;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= UNLOCKED;
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      rgb1_q        <= '0;
      pcnt_q        <= '0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_rgb_q      <= '0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      crc_q         <= 16'hFFFF;
      frame_done_q  <= 1'b0;
      frame_crc_q   <= '0;
    end else begin
      state_q       <= state_d;
      hs1_q         <= hsync;
      hs2_q         <= hs1_q;
      vs1_q         <= vsync;
      vs2_q         <= vs1_q;
      rgb1_q        <= {r_in, g_in, b_in};
      pcnt_q        <= pcnt_d;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_rgb_q      <= px_rgb_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      crc_q         <= crc_d;
      frame_done_q  <= frame_done_d;
      frame_crc_q   <= frame_crc_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_rgb      = px_rgb_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign line_period = line_period_q;
  assign frame_lines = frame_lines_q;
  assign frame_done  = frame_done_q;
  assign frame_crc   = frame_crc_q;
endmodule
